// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// On-chip exhaustive checker for a small combinational block. It walks every
// input vector 0..2^N_IN-1 onto the block, waits SETTLE cycles, samples the
// block's output F and builds the minterm/maxterm masks. At the end it reports
// whether the sampled truth table equals the expected one.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          begin a sweep (only honoured while idle)
//   expected       expected truth table, bit i = F at vector i (captured at start)
//   f_in           output F of the block under test
//   stim           vector driven to the block under test, MSB = A
//   busy           high while a sweep is in progress
//   done           one-cycle pulse when the sweep completes
//   minterm_mask   bit i = sampled F at vector i
//   maxterm_mask   bit i = inverted sampled F at vector i
//   match          minterm_mask equals captured expected (valid from done on)
//   mismatch_count number of vectors where F differed from expected

module truth_table_sweeper #(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 2,
  localparam int V      = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [V-1:0]    expected,
  input  logic            f_in,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    minterm_mask,
  output logic [V-1:0]    maxterm_mask,
  output logic            match,
  output logic [N_IN:0]   mismatch_count
);

  // The hold counter only ever reaches SETTLE-1, so it needs clog2(SETTLE) bits.
  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FINISH
  } state_t;

  state_t            state_q,    state_d;
  logic [HW-1:0]     hold_q,     hold_d;
  logic [N_IN-1:0]   stim_q,     stim_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [V-1:0]      minterm_q,  minterm_d;
  logic [V-1:0]      maxterm_q,  maxterm_d;
  logic              match_q,    match_d;
  logic [N_IN:0]     mm_count_q, mm_count_d;
  logic [V-1:0]      expected_q, expected_d;

  // Next-state and next-output logic for the sweep. Every output is a flop, so
  // all of them are computed here and registered together below. Results are
  // held by default, which keeps the masks stable in IDLE between sweeps.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    minterm_d  = minterm_q;
    maxterm_d  = maxterm_q;
    match_d    = match_q;
    mm_count_d = mm_count_q;
    expected_d = expected_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          expected_d = expected;
          minterm_d  = '0;
          maxterm_d  = '0;
          mm_count_d = '0;
          match_d    = 1'b0;
          stim_d     = '0;
          busy_d     = 1'b1;
          hold_d     = '0;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (hold_q == HW'(SETTLE - 1)) begin
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      SAMPLE: begin
        // Both masks start cleared, so writing only the current bit leaves
        // unsampled positions at 0 in both.
        minterm_d[stim_q] = f_in;
        maxterm_d[stim_q] = ~f_in;
        if (f_in != expected_q[stim_q]) begin
          mm_count_d = mm_count_q + (N_IN + 1)'(1);
        end
        if (stim_q == N_IN'(V - 1)) begin
          state_d = FINISH;
        end else begin
          stim_d  = stim_q + N_IN'(1);
          hold_d  = '0;
          state_d = HOLD;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        match_d = (minterm_q == expected_q);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any partial sweep on the spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      minterm_q  <= '0;
      maxterm_q  <= '0;
      match_q    <= 1'b0;
      mm_count_q <= '0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      minterm_q  <= minterm_d;
      maxterm_q  <= maxterm_d;
      match_q    <= match_d;
      mm_count_q <= mm_count_d;
      expected_q <= expected_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign minterm_mask   = minterm_q;
  assign maxterm_mask   = maxterm_q;
  assign match          = match_q;
  assign mismatch_count = mm_count_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Two sweepers share clock and reset: instance 0 (SETTLE=2) checks a small
// gate-level block selected by mode0, instance 1 (SETTLE=4) sees a constant 1.
// A timeline model predicts every output from the cycle count since start.

module tb_truth_table_sweeper;

  logic clk;
  logic rst;
  logic start0, start1;
  logic [7:0] expected0, expected1;
  int   mode0;
  logic f0, f1;

  logic [2:0] stim_w     [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic [7:0] minterm_w  [2];
  logic [7:0] maxterm_w  [2];
  logic       match_w    [2];
  logic [3:0] cnt_w      [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model state: sweep seen, edges since the accepting start edge, capture.
  bit         m_on   [2];
  int         m_t    [2];
  logic [7:0] m_exp  [2];
  int         m_mode [2];
  int         settle [2] = '{2, 4};

  // Block under test: A = v[2], B = v[1], C = v[0].
  //   0: A|B|C                      (table FE)
  //   1: (A+B'+C)(A'+B+C')          (faulted maxterm form, table DB)
  //   2: constant 1
  //   3: (A+B+C)(A+B'+C)(A'+B+C')   (table DA)
  function automatic logic block_f(input int mode, input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (mode)
      0:       return a | b | c;
      1:       return (a | ~b | c) & (~a | b | ~c);
      2:       return 1'b1;
      default: return (a | b | c) & (a | ~b | c) & (~a | b | ~c);
    endcase
  endfunction

  assign f0 = block_f(mode0, stim_w[0]);
  assign f1 = 1'b1;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0), .f_in(f0),
    .stim(stim_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .minterm_mask(minterm_w[0]), .maxterm_mask(maxterm_w[0]),
    .match(match_w[0]), .mismatch_count(cnt_w[0])
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .f_in(f1),
    .stim(stim_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .minterm_mask(minterm_w[1]), .maxterm_mask(maxterm_w[1]),
    .match(match_w[1]), .mismatch_count(cnt_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track time since the accepted start. A start is taken when no sweep has
  // run yet or the previous one has already reached its done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_on[i] <= 1'b0;
        m_t[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((!m_on[i] || m_t[i] >= 8 * (settle[i] + 1) + 1) &&
            ((i == 0) ? start0 : start1)) begin
          m_on[i]   <= 1'b1;
          m_t[i]    <= 0;
          m_exp[i]  <= (i == 0) ? expected0 : expected1;
          m_mode[i] <= (i == 0) ? mode0 : 2;
        end else if (m_on[i] && m_t[i] < 8 * (settle[i] + 1) + 2) begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs of instance i: vector k is on stim during edges
  // k*(S+1)..(k+1)*(S+1)-1 and has been sampled once (k+1)*(S+1) edges passed.
  task automatic checkInst(input int i);
    int         per, len, n, t, cnt;
    logic [2:0] stim_e;
    logic       busy_e, done_e, match_e, f;
    logic [7:0] fm, xm;
    per = settle[i] + 1;
    len = 8 * per;
    fm = '0; xm = '0; cnt = 0;
    stim_e = '0; busy_e = 0; done_e = 0; match_e = 0;
    if (m_on[i]) begin
      t = m_t[i];
      n = (t / per > 8) ? 8 : t / per;
      stim_e = (t / per > 7) ? 3'd7 : 3'(t / per);
      busy_e = (t <= len);
      done_e = (t == len + 1);
      for (int j = 0; j < n; j++) begin
        f = block_f(m_mode[i], 3'(j));
        fm[j] = f;
        xm[j] = ~f;
        if (f != m_exp[i][j]) cnt++;
      end
      match_e = (t >= len + 1) && (fm == m_exp[i]);
    end
    checkOutput($sformatf("inst%0d stim", i),    64'(stim_w[i]),    64'(stim_e));
    checkOutput($sformatf("inst%0d busy", i),    64'(busy_w[i]),    64'(busy_e));
    checkOutput($sformatf("inst%0d done", i),    64'(done_w[i]),    64'(done_e));
    checkOutput($sformatf("inst%0d minterm", i), 64'(minterm_w[i]), 64'(fm));
    checkOutput($sformatf("inst%0d maxterm", i), 64'(maxterm_w[i]), 64'(xm));
    checkOutput($sformatf("inst%0d match", i),   64'(match_w[i]),   64'(match_e));
    checkOutput($sformatf("inst%0d count", i),   64'(cnt_w[i]),     64'(cnt));
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) checkInst(i);
    end
  end

  // Run one sweep on instance inst. Start is seen at edge 0; extra start
  // pulses are seen at edges re_a/re_b, reset is applied just before edge
  // rst_at, and expected is flipped just before edge 7 to show it is ignored.
  task automatic applyStimulus(input int inst, input logic [7:0] exp,
                               input int mode, input int re_a, input int re_b,
                               input int rst_at, output int done_edge,
                               output int pulses);
    done_edge = -1;
    pulses    = 0;
    @(negedge clk); #1;
    if (inst == 0) begin
      expected0 = exp; mode0 = mode; start0 = 1'b1;
    end else begin
      expected1 = exp; start1 = 1'b1;
    end
    @(posedge clk); @(negedge clk); #1;
    for (int e = 1; e <= 100; e++) begin
      if (inst == 0) start0 = (e == re_a) || (e == re_b);
      else           start1 = (e == re_a) || (e == re_b);
      if (e == 7) begin
        if (inst == 0) expected0 = ~exp;
        else           expected1 = ~exp;
      end
      rst = (e == rst_at);
      @(posedge clk); @(negedge clk); #1;
      if (done_w[inst]) begin
        pulses++;
        if (done_edge < 0) done_edge = e;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int de, dp;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    expected0 = '0; expected1 = '0;
    mode0 = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    $display("[TB] reset then idle");
    dp = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (done_w[0] || done_w[1]) dp++;
    end
    checkOutput("idle done pulses", 64'(dp), 64'd0);
    checkOutput("idle stim", 64'(stim_w[0]), 64'd0);
    checkOutput("idle busy", 64'(busy_w[0]), 64'd0);
    checkOutput("idle minterm", 64'(minterm_w[0]), 64'h00);
    checkOutput("idle maxterm", 64'(maxterm_w[0]), 64'h00);

    $display("[TB] F = A|B|C, expected FE");
    applyStimulus(0, 8'hFE, 0, -1, -1, -1, de, dp);
    checkOutput("or3 done edge", 64'(de), 64'd25);
    checkOutput("or3 done pulses", 64'(dp), 64'd1);
    checkOutput("or3 minterm", 64'(minterm_w[0]), 64'hFE);
    checkOutput("or3 maxterm", 64'(maxterm_w[0]), 64'h01);
    checkOutput("or3 match", 64'(match_w[0]), 64'd1);
    checkOutput("or3 count", 64'(cnt_w[0]), 64'd0);

    $display("[TB] faulted maxterm block, expected DA");
    applyStimulus(0, 8'hDA, 1, -1, -1, -1, de, dp);
    checkOutput("fault minterm", 64'(minterm_w[0]), 64'hDB);
    checkOutput("fault maxterm", 64'(maxterm_w[0]), 64'h24);
    checkOutput("fault match", 64'(match_w[0]), 64'd0);
    checkOutput("fault count", 64'(cnt_w[0]), 64'd1);

    $display("[TB] SETTLE=4 with constant F=1");
    applyStimulus(1, 8'hFF, 2, -1, -1, -1, de, dp);
    checkOutput("settle4 done edge", 64'(de), 64'd41);
    checkOutput("settle4 minterm", 64'(minterm_w[1]), 64'hFF);
    checkOutput("settle4 maxterm", 64'(maxterm_w[1]), 64'h00);
    checkOutput("settle4 match", 64'(match_w[1]), 64'd1);

    $display("[TB] start re-pulsed at edges 5 and 12");
    applyStimulus(0, 8'hFE, 0, 5, 12, -1, de, dp);
    checkOutput("busy done edge", 64'(de), 64'd25);
    checkOutput("busy done pulses", 64'(dp), 64'd1);

    $display("[TB] start seen in FINISH is ignored");
    applyStimulus(0, 8'hFE, 0, 25, -1, -1, de, dp);
    checkOutput("finish start pulses", 64'(dp), 64'd1);

    $display("[TB] start during the done cycle is taken");
    applyStimulus(0, 8'hFE, 0, 26, -1, -1, de, dp);
    checkOutput("done-cycle start pulses", 64'(dp), 64'd2);

    $display("[TB] reset mid-sweep, then a fresh sweep");
    applyStimulus(0, 8'hDA, 3, -1, -1, 10, de, dp);
    checkOutput("aborted done pulses", 64'(dp), 64'd0);
    checkOutput("aborted minterm", 64'(minterm_w[0]), 64'h00);
    checkOutput("aborted maxterm", 64'(maxterm_w[0]), 64'h00);
    checkOutput("aborted count", 64'(cnt_w[0]), 64'd0);
    applyStimulus(0, 8'hDA, 3, -1, -1, -1, de, dp);
    checkOutput("fresh done edge", 64'(de), 64'd25);
    checkOutput("fresh done pulses", 64'(dp), 64'd1);
    checkOutput("fresh minterm", 64'(minterm_w[0]), 64'hDA);
    checkOutput("fresh maxterm", 64'(maxterm_w[0]), 64'h25);
    checkOutput("fresh match", 64'(match_w[0]), 64'd1);
    checkOutput("fresh count", 64'(cnt_w[0]), 64'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
